// File: rtl/reg_read_pipe.sv
// Register-read lane: issue latch (S), PRF read plus writeback bypass, output stage (O).
// Optional writeback bypass is enabled by defining RR_BYPASS_EN.
module reg_read_pipe #(
    parameter int NUM_PREGS    = 64,
    parameter int NUM_EX_PIPES = 8,
    parameter int ROB_IDX_W    = 6,
    parameter int PAYLOAD_W    = 32,
    parameter int PREG_W       = $clog2(NUM_PREGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           iss_valid,
    output logic                           iss_ready,
    input  logic [PREG_W-1:0]              iss_src1_index,
    input  logic [PREG_W-1:0]              iss_src2_index,
    input  logic [PREG_W-1:0]              iss_dst_index,
    input  logic [ROB_IDX_W-1:0]           iss_rob_id,
    input  logic [PAYLOAD_W-1:0]           iss_payload,
    output logic [PREG_W-1:0]              prf_src1_index,
    output logic [PREG_W-1:0]              prf_src2_index,
    input  logic [31:0]                    prf_src1_val,
    input  logic [31:0]                    prf_src2_val,
    input  logic [NUM_EX_PIPES-1:0]        wb_valid,
    input  logic [NUM_EX_PIPES*PREG_W-1:0] wb_dst_index,
    input  logic [NUM_EX_PIPES*32-1:0]     wb_dst_val,
    output logic                           ex_valid,
    input  logic                           ex_ready,
    output logic [31:0]                    ex_src1_val,
    output logic [31:0]                    ex_src2_val,
    output logic [PREG_W-1:0]              ex_dst_index,
    output logic [ROB_IDX_W-1:0]           ex_rob_id,
    output logic [PAYLOAD_W-1:0]           ex_payload
);

    logic                 s_valid_q, s_valid_d;
    logic [PREG_W-1:0]    s_src1_q, s_src1_d;
    logic [PREG_W-1:0]    s_src2_q, s_src2_d;
    logic [PREG_W-1:0]    s_dst_q, s_dst_d;
    logic [ROB_IDX_W-1:0] s_rob_q, s_rob_d;
    logic [PAYLOAD_W-1:0] s_pay_q, s_pay_d;

    logic                 o_valid_q, o_valid_d;
    logic [31:0]          o_op1_q, o_op1_d;
    logic [31:0]          o_op2_q, o_op2_d;
    logic [PREG_W-1:0]    o_dst_q, o_dst_d;
    logic [ROB_IDX_W-1:0] o_rob_q, o_rob_d;
    logic [PAYLOAD_W-1:0] o_pay_q, o_pay_d;

    logic        o_free, s_adv, accept;
    logic [31:0] op1, op2;

    assign o_free    = !o_valid_q || ex_ready;
    assign s_adv     = s_valid_q && o_free;
    assign iss_ready = !s_valid_q || o_free;
    assign accept    = iss_valid && iss_ready;

    assign prf_src1_index = s_src1_q;
    assign prf_src2_index = s_src2_q;

    // Descending scan so the lowest-numbered matching pipe wins.
    always_comb begin
        op1 = prf_src1_val;
        op2 = prf_src2_val;
`ifdef RR_BYPASS_EN
        for (int i = NUM_EX_PIPES - 1; i >= 0; i--) begin
            if (wb_valid[i] && wb_dst_index[i*PREG_W +: PREG_W] == s_src1_q)
                op1 = wb_dst_val[i*32 +: 32];
            if (wb_valid[i] && wb_dst_index[i*PREG_W +: PREG_W] == s_src2_q)
                op2 = wb_dst_val[i*32 +: 32];
        end
`endif
        if (s_src1_q == '0)
            op1 = '0;
        if (s_src2_q == '0)
            op2 = '0;
    end

`ifndef RR_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_dst_index, wb_dst_val};
`endif

    always_comb begin
        s_valid_d = s_valid_q;
        s_src1_d  = s_src1_q;
        s_src2_d  = s_src2_q;
        s_dst_d   = s_dst_q;
        s_rob_d   = s_rob_q;
        s_pay_d   = s_pay_q;
        if (accept) begin
            s_valid_d = 1'b1;
            s_src1_d  = iss_src1_index;
            s_src2_d  = iss_src2_index;
            s_dst_d   = iss_dst_index;
            s_rob_d   = iss_rob_id;
            s_pay_d   = iss_payload;
        end else if (s_adv) begin
            s_valid_d = 1'b0;
        end
        if (flush)
            s_valid_d = 1'b0;
    end

    always_comb begin
        o_valid_d = o_valid_q;
        o_op1_d   = o_op1_q;
        o_op2_d   = o_op2_q;
        o_dst_d   = o_dst_q;
        o_rob_d   = o_rob_q;
        o_pay_d   = o_pay_q;
        if (s_adv) begin
            o_valid_d = 1'b1;
            o_op1_d   = op1;
            o_op2_d   = op2;
            o_dst_d   = s_dst_q;
            o_rob_d   = s_rob_q;
            o_pay_d   = s_pay_q;
        end else if (ex_ready) begin
            o_valid_d = 1'b0;
        end
        if (flush)
            o_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_valid_q <= 1'b0;
            s_src1_q  <= '0;
            s_src2_q  <= '0;
            s_dst_q   <= '0;
            s_rob_q   <= '0;
            s_pay_q   <= '0;
            o_valid_q <= 1'b0;
            o_op1_q   <= '0;
            o_op2_q   <= '0;
            o_dst_q   <= '0;
            o_rob_q   <= '0;
            o_pay_q   <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_src1_q  <= s_src1_d;
            s_src2_q  <= s_src2_d;
            s_dst_q   <= s_dst_d;
            s_rob_q   <= s_rob_d;
            s_pay_q   <= s_pay_d;
            o_valid_q <= o_valid_d;
            o_op1_q   <= o_op1_d;
            o_op2_q   <= o_op2_d;
            o_dst_q   <= o_dst_d;
            o_rob_q   <= o_rob_d;
            o_pay_q   <= o_pay_d;
        end
    end

    assign ex_valid     = o_valid_q;
    assign ex_src1_val  = o_op1_q;
    assign ex_src2_val  = o_op2_q;
    assign ex_dst_index = o_dst_q;
    assign ex_rob_id    = o_rob_q;
    assign ex_payload   = o_pay_q;

endmodule

// File: tb/tb_reg_read_pipe.sv
// Bench for reg_read_pipe: two-deep queue model checked every cycle plus directed literals.
// Bypass expectations follow RR_BYPASS_EN.
module tb_reg_read_pipe;

    localparam int NP = 8;
`ifdef RR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst, flush, iss_valid, iss_ready, ex_valid, ex_ready;
    logic [5:0]      iss_src1_index, iss_src2_index, iss_dst_index, iss_rob_id;
    logic [31:0]     iss_payload;
    logic [5:0]      prf_src1_index, prf_src2_index;
    logic [31:0]     prf_src1_val, prf_src2_val;
    logic [NP-1:0]   wb_valid;
    logic [NP*6-1:0] wb_dst_index;
    logic [NP*32-1:0] wb_dst_val;
    logic [31:0]     ex_src1_val, ex_src2_val, ex_payload;
    logic [5:0]      ex_dst_index, ex_rob_id;

    logic [31:0] prf [64];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign prf_src1_val = prf[prf_src1_index];
    assign prf_src2_val = prf[prf_src2_index];

    reg_read_pipe dut (
        .clk(clk), .rst(rst), .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_src1_index(iss_src1_index), .iss_src2_index(iss_src2_index),
        .iss_dst_index(iss_dst_index), .iss_rob_id(iss_rob_id),
        .iss_payload(iss_payload),
        .prf_src1_index(prf_src1_index), .prf_src2_index(prf_src2_index),
        .prf_src1_val(prf_src1_val), .prf_src2_val(prf_src2_val),
        .wb_valid(wb_valid), .wb_dst_index(wb_dst_index), .wb_dst_val(wb_dst_val),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_src1_val(ex_src1_val), .ex_src2_val(ex_src2_val),
        .ex_dst_index(ex_dst_index), .ex_rob_id(ex_rob_id),
        .ex_payload(ex_payload)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [5:0]  s1, s2, dst, rob;
        logic [31:0] pay;
        bit          res;
        logic [31:0] v1, v2;
    } uop_t;

    uop_t q[$];
    bit clean_o = 1'b1;
    bit clean_s = 1'b1;

    function automatic logic [31:0] operand(input logic [5:0] idx);
        if (idx == 6'd0)
            return 32'h0;
        if (BYP) begin
            for (int i = 0; i < NP; i++)
                if (wb_valid[i] && wb_dst_index[i*6 +: 6] == idx)
                    return wb_dst_val[i*32 +: 32];
        end
        return prf[idx];
    endfunction

    // Model: lane is a queue of at most two uops; the head, once resolved, is on ex_*.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            automatic bit exp_v = q.size() > 0 && q[0].res;
            automatic bit pop, acc;
            uop_t u;
            chk("ex_valid", ex_valid, exp_v);
            chk("iss_ready", iss_ready, q.size() < 2 || ex_ready);
            if (exp_v) begin
                chk("ex_src1", ex_src1_val, q[0].v1);
                chk("ex_src2", ex_src2_val, q[0].v2);
                chk("ex_dst", ex_dst_index, q[0].dst);
                chk("ex_rob", ex_rob_id, q[0].rob);
                chk("ex_pay", ex_payload, q[0].pay);
            end
            if (q.size() > 0 && !q[q.size()-1].res) begin
                chk("prf_idx1", prf_src1_index, q[q.size()-1].s1);
                chk("prf_idx2", prf_src2_index, q[q.size()-1].s2);
            end
            if (clean_o) begin
                chk("clr_ex", {ex_src1_val ^ ex_src2_val ^ ex_payload}, 32'h0);
                chk("clr_ex_src1", ex_src1_val, 32'h0);
                chk("clr_ex_ids", {ex_dst_index, ex_rob_id}, 32'h0);
            end
            if (clean_s)
                chk("clr_prf_idx", {prf_src1_index, prf_src2_index}, 32'h0);

            if (!rst) begin
                q.delete();
                clean_o = 1'b1;
                clean_s = 1'b1;
            end else if (flush) begin
                q.delete();
            end else begin
                pop = q.size() > 0 && q[0].res && ex_ready;
                acc = iss_valid && (q.size() < 2 || ex_ready);
                if (pop)
                    void'(q.pop_front());
                if (q.size() > 0 && !q[0].res) begin
                    q[0].v1 = operand(q[0].s1);
                    q[0].v2 = operand(q[0].s2);
                    q[0].res = 1'b1;
                    clean_o = 1'b0;
                end
                if (acc) begin
                    u.s1 = iss_src1_index;
                    u.s2 = iss_src2_index;
                    u.dst = iss_dst_index;
                    u.rob = iss_rob_id;
                    u.pay = iss_payload;
                    u.res = 1'b0;
                    u.v1 = 32'h0;
                    u.v2 = 32'h0;
                    q.push_back(u);
                    clean_s = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] s1, input logic [5:0] s2,
                         input logic [5:0] d, input logic [5:0] r,
                         input logic [31:0] p);
        iss_valid = 1'b1;
        iss_src1_index = s1;
        iss_src2_index = s2;
        iss_dst_index = d;
        iss_rob_id = r;
        iss_payload = p;
    endtask

    task automatic set_wb(input int i, input logic [5:0] idx, input logic [31:0] v);
        wb_valid[i] = 1'b1;
        wb_dst_index[i*6 +: 6] = idx;
        wb_dst_val[i*32 +: 32] = v;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b1;
        wb_valid = '0;
        wb_dst_index = '0;
        wb_dst_val = '0;
        issue(0, 0, 0, 0, 0);
        iss_valid = 1'b0;
        for (int i = 0; i < 64; i++)
            prf[i] = 32'h100 + i;
        prf[0] = 32'hFFFF;
        prf[5] = 32'h1234;
        prf[6] = 32'h55;
        prf[7] = 32'h70;
        prf[9] = 32'h0;
        tick();
        tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_rob", ex_rob_id, 0);
        chk("rst_prf_idx", prf_src1_index, 0);
        rst = 1'b1;
        tick();
        chk("rst_iss_ready", iss_ready, 1);

        // basic read
        issue(5, 6, 10, 3, 32'hCAFE0001);
        tick();
        iss_valid = 1'b0;
        chk("t1_not_yet", ex_valid, 0);
        tick();
        chk("t1_valid", ex_valid, 1);
        chk("t1_src1", ex_src1_val, 32'h1234);
        chk("t1_src2", ex_src2_val, 32'h55);
        chk("t1_rob", ex_rob_id, 3);
        chk("t1_pay", ex_payload, 32'hCAFE0001);
        tick();
        chk("t1_gone", ex_valid, 0);

        // bypass
        issue(9, 0, 11, 4, 32'h2);
        tick();
        iss_valid = 1'b0;
        set_wb(2, 9, 32'hDEAD);
        tick();
        wb_valid = '0;
        chk("t2_byp", ex_src1_val, BYP ? 32'hDEAD : 32'h0);
        chk("t2_p0", ex_src2_val, 32'h0);
        issue(9, 9, 12, 5, 32'h3);
        tick();
        iss_valid = 1'b0;
        set_wb(0, 9, 32'hA);
        set_wb(4, 9, 32'hB);
        tick();
        wb_valid = '0;
        chk("t2_low1", ex_src1_val, BYP ? 32'hA : 32'h0);
        chk("t2_low2", ex_src2_val, BYP ? 32'hA : 32'h0);
        tick();

        // backpressure and stall refresh
        ex_ready = 1'b0;
        issue(5, 6, 13, 20, 32'h20);
        tick();
        issue(1, 7, 14, 21, 32'h21);
        tick();
        issue(2, 3, 15, 22, 32'h22);
        #1;
        chk("t3_full", iss_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1)
                prf[7] = 32'h77;
            chk("t3_hold_v", ex_valid, 1);
            chk("t3_hold_rob", ex_rob_id, 20);
            chk("t3_hold_src1", ex_src1_val, 32'h1234);
        end
        ex_ready = 1'b1;
        tick();
        iss_valid = 1'b0;
        chk("t3_rob21", ex_rob_id, 21);
        chk("t4_refresh", ex_src2_val, 32'h77);
        chk("t3_src1_21", ex_src1_val, 32'h101);
        tick();
        chk("t3_rob22", ex_rob_id, 22);
        chk("t3_src2_22", ex_src2_val, 32'h103);
        tick();
        chk("t3_drained", ex_valid, 0);

        // flush
        issue(5, 6, 16, 30, 32'h30);
        tick();
        issue(5, 6, 17, 31, 32'h31);
        tick();
        chk("t5_rob30", ex_rob_id, 30);
        issue(5, 6, 18, 32, 32'h32);
        flush = 1'b1;
        #1;
        chk("t5_rdy_flush", iss_ready, 1);
        tick();
        flush = 1'b0;
        iss_valid = 1'b0;
        chk("t5_killed", ex_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_quiet", ex_valid, 0);
        end

        // zero reg, then reset mid-stream
        set_wb(1, 0, 32'hFFFF);
        issue(0, 5, 19, 33, 32'h33);
        tick();
        iss_valid = 1'b0;
        tick();
        wb_valid = '0;
        chk("t6_zero", ex_src1_val, 32'h0);
        chk("t6_src2", ex_src2_val, 32'h1234);
        issue(5, 6, 20, 40, 32'h40);
        tick();
        issue(6, 5, 21, 41, 32'h41);
        tick();
        rst = 1'b0;
        issue(7, 7, 22, 42, 32'h42);
        tick();
        rst = 1'b1;
        iss_valid = 1'b0;
        chk("t6_rst_v", ex_valid, 0);
        chk("t6_rst_src1", ex_src1_val, 0);
        chk("t6_rst_pay", ex_payload, 0);
        chk("t6_rst_rob", ex_rob_id, 0);
        chk("t6_rst_prf", prf_src2_index, 0);
        chk("t6_rst_rdy", iss_ready, 1);
        tick();
        chk("t6_rst_quiet", ex_valid, 0);
        issue(6, 5, 23, 50, 32'h50);
        tick();
        iss_valid = 1'b0;
        tick();
        chk("t6_recov_v", ex_valid, 1);
        chk("t6_recov_rob", ex_rob_id, 50);
        chk("t6_recov_src1", ex_src1_val, 32'h55);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_read_pipe.md
Name: reg_read_pipe

Overview:
- One register-read lane placed between the issue queue and one execute pipe. Instantiated NUM_EX_PIPES times.
- Each instance latches an issued uop and drives that uop's source indices onto its physical-register-file read port.
- It merges the PRF data with same-cycle execute writeback bypass and presents a registered, operand-complete uop to execute.
- Provides valid/ready backpressure in both directions and a global flush.

Parameters:
NUM_PREGS, 64, physical register count; PREG_W = $clog2(NUM_PREGS)
NUM_EX_PIPES, 8, number of writeback/bypass buses
ROB_IDX_W, 6, ROB tag width
PAYLOAD_W, 32, opaque uop payload (opcode, funct, immediate), passed through unchanged

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
flush  input  1  kill all in-flight uops
iss_valid  input  1  issue presents uop
iss_ready  output  1  lane can accept
iss_src1_index, iss_src2_index  input  PREG_W  source pregs
iss_dst_index  input  PREG_W  destination preg
iss_rob_id  input  ROB_IDX_W  ROB tag
iss_payload  input  PAYLOAD_W  passthrough
prf_src1_index, prf_src2_index  output  PREG_W  PRF read address
prf_src1_val, prf_src2_val  input  32  PRF read data, combinational from address
wb_valid  input  NUM_EX_PIPES  writeback valid per pipe
wb_dst_index  input  NUM_EX_PIPES*PREG_W  writeback preg, pipe i at bits [i*PREG_W +: PREG_W]
wb_dst_val  input  NUM_EX_PIPES*32  writeback value
ex_valid  output  1  operand-complete uop valid
ex_ready  input  1  execute accepts
ex_src1_val, ex_src2_val  output  32  operands
ex_dst_index  output  PREG_W  destination preg
ex_rob_id  output  ROB_IDX_W  ROB tag
ex_payload  output  PAYLOAD_W  passthrough

Behaviour:
- Two register stages:
  - S (read stage): valid plus indices, dst, rob, payload.
  - O (output stage): valid plus operands, dst, rob, payload.
- Reset (rst==0 at posedge):
  - S.valid=0, O.valid=0.
  - All O/S data fields cleared to 0; therefore ex_valid=0 and all ex_* outputs=0.
  - iss_ready=1 from the first cycle after reset deasserts.
  - prf_src*_index = 0.
- prf_src1_index/prf_src2_index are combinational from S, valid or not.
- Transfer rules:
  - o_free = !O.valid || ex_ready.
  - s_adv = S.valid && o_free.
  - iss_ready = !S.valid || o_free. This is combinational and must not depend on iss_valid.
  - Accept = iss_valid && iss_ready: S loads at the edge.
  - s_adv: O loads from S at the edge.
  - O.valid clears when ex_ready is high and S is not advancing.
- Operand selection, evaluated in the s_adv cycle, per source:
  - If any wb_valid[i] with wb_dst_index[i]==src_index, use wb_dst_val of the lowest such i.
  - Otherwise use prf_src_val.
  - Preg 0 always yields 0 regardless of PRF or bypass.
- Stall: while S is held, bypass is re-evaluated each cycle. PRF writes land each edge, so S always sees current values. No operand capture in S.
- Latency: uop accepted at edge N appears with ex_valid=1 after edge N+1 when unstalled. Throughput is 1 uop/cycle.
- Flush: at the edge with flush=1, S.valid=0 and O.valid=0. A same-cycle accept is dropped. flush does not affect iss_ready combinationally.
- Reset mid-operation behaves identically to flush and also clears data.
- Output stability: while ex_valid=1 and ex_ready=0, all ex_* outputs hold constant.

Optional Feature:
- Macro RR_BYPASS_EN.
- Defined: the writeback bypass described above is active.
- Undefined:
  - wb_* ports remain present but are ignored.
  - Operands come only from PRF (preg 0 still reads 0).
  - Issue wakeup must then be delayed one cycle by the scheduler.
  - Latency and handshake are unchanged.

Test Plan:
1. Basic read with bypass off: PRF p5=0x1234, p6=0x55. Issue src1=5, src2=6, rob=3. ex_valid rises 2 edges after iss_valid; ex_src1_val=0x1234, ex_src2_val=0x55, ex_rob_id=3.
2. Bypass (RR_BYPASS_EN): uop src1=9 in S while wb_valid[2]=1, wb_dst_index[2]=9, wb_dst_val=0xDEAD, PRF p9=0 → ex_src1_val=0xDEAD. Also drive pipe 0 and pipe 4 to p9 with 0xA and 0xB → 0xA selected.
3. Backpressure: ex_ready=0 with O full and S full → iss_ready=0. ex_* stays stable 5 cycles. Release ex_ready; the 3 uops drain back-to-back in order with no loss or duplication.
4. Stall refresh: S holds src2=7 during the stall. PRF p7 written 0x77 at the stall's second edge → ex_src2_val=0x77 after release.
5. Flush: O and S valid, iss_valid=1, flush=1 → next cycle ex_valid=0 and no uop emerges later. The issued uop is dropped.
6. Zero reg and reset: src1=0 with bypass on p0=0xFFFF → ex_src1_val=0. Assert rst=0 mid-stream for 1 cycle → all outputs 0, iss_ready=1 afterward.
